// File: rtl/srrc_symbol_upsampler.sv
// srrc_symbol_upsampler
//   Front end for the 33-tap SRRC pulse-shaping filter. Buffers a bit stream
//   through a valid/ready FIFO, maps each bit to an antipodal 2-bit symbol
//   (0 -> 2'b01 = +1.0, 1 -> 2'b11 = -1.0), zero-stuffs every symbol to OSR
//   samples, and on starvation emits FLUSH_LEN zero samples so the filter
//   delay line holds no stale tail.
//
// Optional build macro:
//   SRRC_DIFF_ENC_EN - differential encoding: each popped bit is XORed with
//                      the previously transmitted encoded bit before mapping.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   en         global advance enable; low freezes the state machine
//   bit_in     payload bit
//   bit_valid  bit_in is valid
//   bit_ready  FIFO can accept a bit
//   sym_out    symbol to the filter (2'b01 / 2'b11 / 2'b00)
//   sym_en     sym_out valid this cycle; drives the filter enable
//   underrun   sticky: a symbol slot found the FIFO empty
//   busy       state machine is not idle
module srrc_symbol_upsampler #(
  parameter int OSR        = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int PRIME      = 2,
  parameter int FLUSH_LEN  = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [1:0] sym_out,
  output logic       sym_en,
  output logic       underrun,
  output logic       busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic [FW-1:0] flush_cnt, flush_n;

  logic          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic          push, pop;
  logic          tx_bit;
  logic [1:0]    sym_n;
  logic          sym_en_n;
  logic          set_undr;

  assign bit_ready = (count < (AW+1)'(FIFO_DEPTH));
  assign push      = bit_valid && bit_ready;
  assign busy      = (state != S_IDLE);

`ifdef SRRC_DIFF_ENC_EN
  logic enc_q;
  assign tx_bit = mem[rd_ptr] ^ enc_q;
`else
  assign tx_bit = mem[rd_ptr];
`endif

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    flush_n  = flush_cnt;
    pop      = 1'b0;
    sym_n    = 2'b00;
    sym_en_n = 1'b0;
    set_undr = 1'b0;
    if (en) begin
      unique case (state)
        S_IDLE: begin
          if (count >= (AW+1)'(PRIME)) begin
            state_n = S_RUN;
            phase_n = '0;
          end
        end
        S_RUN: begin
          sym_en_n = 1'b1;
          if (phase == '0 && count == '0) begin
            // The underrun sample is the first of the FLUSH_LEN zeros.
            set_undr = 1'b1;
            if (FLUSH_LEN > 1) begin
              flush_n = FW'(FLUSH_LEN - 1);
              state_n = S_FLUSH;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            if (phase == '0) begin
              pop   = 1'b1;
              sym_n = tx_bit ? 2'b11 : 2'b01;
            end
            phase_n = (phase == PW'(OSR - 1)) ? '0 : phase + 1'b1;
          end
        end
        S_FLUSH: begin
          sym_en_n = 1'b1;
          flush_n  = flush_cnt - 1'b1;
          if (flush_cnt == FW'(1)) begin
            state_n = S_IDLE;
            phase_n = '0;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase     <= '0;
      flush_cnt <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      sym_out   <= 2'b00;
      sym_en    <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      flush_cnt <= flush_n;
      sym_out   <= sym_n;
      sym_en    <= sym_en_n;
      underrun  <= underrun | set_undr;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SRRC_DIFF_ENC_EN
  always_ff @(posedge clk) begin
    if (rst)      enc_q <= 1'b0;
    else if (pop) enc_q <= tx_bit;
  end
`endif

endmodule

// File: tb/tb_srrc_symbol_upsampler.sv
// Self-checking bench for srrc_symbol_upsampler. A queue-based reference
// model predicts every output each cycle; directed literal checks pin the
// model to hand-computed sequences.
module tb_srrc_symbol_upsampler;
  localparam int OSR       = 4;
  localparam int DEPTH     = 4;
  localparam int PRIME     = 2;
  localparam int FLUSH_LEN = 33;

  logic       clk = 1'b0;
  logic       rst, en, bit_in, bit_valid;
  logic       bit_ready;
  logic [1:0] sym_out;
  logic       sym_en, underrun, busy;

  always #5 clk = ~clk;

  srrc_symbol_upsampler #(
    .OSR(OSR), .FIFO_DEPTH(DEPTH), .PRIME(PRIME), .FLUSH_LEN(FLUSH_LEN)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .sym_out(sym_out), .sym_en(sym_en),
    .underrun(underrun), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: bits waiting, samples still owed for the current
  // symbol or flush, and whether the block is streaming.
  bit mq[$];
  int pend[$];
  bit m_active, m_drain, m_undr, m_prev;
  int e_sym, e_en, e_undr, e_busy, e_rdy;
  int slog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pushed, b;
    if (rst) begin
      mq.delete(); pend.delete();
      m_active = 0; m_drain = 0; m_undr = 0; m_prev = 0;
      e_sym = 0; e_en = 0;
    end else begin
      pushed = bit_valid && (mq.size() < DEPTH);
      e_sym = 0; e_en = 0;
      if (en) begin
        if (!m_active) begin
          if (mq.size() >= PRIME) m_active = 1;
        end else begin
          if (pend.size() == 0) begin
            if (mq.size() > 0) begin
              b = mq.pop_front();
`ifdef SRRC_DIFF_ENC_EN
              b = b ^ m_prev;
              m_prev = b;
`endif
              pend.push_back(b ? 3 : 1);
              repeat (OSR - 1) pend.push_back(0);
            end else begin
              m_undr = 1;
              m_drain = 1;
              repeat (FLUSH_LEN) pend.push_back(0);
            end
          end
          e_sym = pend.pop_front();
          e_en = 1;
          if (m_drain && pend.size() == 0) begin
            m_active = 0;
            m_drain = 0;
          end
        end
      end
      if (pushed) mq.push_back(bit_in);
    end
    e_undr = m_undr;
    e_busy = m_active;
    e_rdy  = (mq.size() < DEPTH);
  endtask

  task automatic tick(input logic r, input logic e, input logic v, input logic b);
    rst = r; en = e; bit_valid = v; bit_in = b;
    model_step();
    @(posedge clk);
    #1;
    check("sym_out", 32'(sym_out), e_sym);
    check("sym_en", 32'(sym_en), e_en);
    check("underrun", 32'(underrun), e_undr);
    check("busy", 32'(busy), e_busy);
    check("bit_ready", 32'(bit_ready), e_rdy);
    if (sym_en === 1'b1) slog.push_back(int'(sym_out));
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    slog.delete();
  endtask

  int exp_seq[16];
  int zeros;
  logic [3:0] pat;
  bit dense;

  initial begin
    rst = 1; en = 0; bit_valid = 0; bit_in = 0;

    // Reset state
    do_reset();
    check("reset_sym_out", 32'(sym_out), 0);
    check("reset_sym_en", 32'(sym_en), 0);
    check("reset_ready", 32'(bit_ready), 1);
    check("reset_busy", 32'(busy), 0);

    // Bits 0,1,1,0 then underrun flush
    pat = 4'b0110;
    for (int i = 0; i < 4; i++) tick(0, 1, 1, pat[3-i]);
    repeat (60) tick(0, 1, 0, 0);
`ifdef SRRC_DIFF_ENC_EN
    exp_seq = '{1,0,0,0, 3,0,0,0, 1,0,0,0, 1,0,0,0};
`else
    exp_seq = '{1,0,0,0, 3,0,0,0, 3,0,0,0, 1,0,0,0};
`endif
    check("t1_len", slog.size(), 16 + FLUSH_LEN);
    for (int i = 0; i < 16; i++)
      if (i < slog.size()) check("t1_sample", slog[i], exp_seq[i]);
    zeros = 0;
    for (int i = 16; i < slog.size(); i++) if (slog[i] == 0) zeros++;
    check("t1_flush_zeros", zeros, FLUSH_LEN);
    check("t1_underrun", 32'(underrun), 1);
    check("t1_idle", 32'(busy), 0);

    // Single push stays idle below PRIME
    do_reset();
    tick(0, 1, 1, 1);
    repeat (5) tick(0, 1, 0, 0);
    check("prime_busy", 32'(busy), 0);
    check("prime_sym_en", 32'(sym_en), 0);
    tick(0, 1, 1, 0);
    check("prime_busy_push", 32'(busy), 0);
    tick(0, 1, 0, 0);
    check("prime_run", 32'(busy), 1);
    repeat (60) tick(0, 1, 0, 0);

    // Backpressure with en low
    do_reset();
    repeat (6) tick(0, 0, 1, 1);
    check("bp_full", 32'(bit_ready), 0);
    tick(0, 1, 0, 0);
    check("bp_still_full", 32'(bit_ready), 0);
    tick(0, 1, 0, 0);
    check("bp_after_pop", 32'(bit_ready), 1);
    repeat (70) tick(0, 1, 0, 0);

    // Stall at phase 2, two bits then underrun
    do_reset();
    tick(0, 1, 1, 0);
    tick(0, 1, 1, 1);
    repeat (3) tick(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0);
      check("stall_sym_en", 32'(sym_en), 0);
      check("stall_sym_out", 32'(sym_out), 0);
    end
    repeat (50) tick(0, 1, 0, 0);
    check("stall_len", slog.size(), 8 + FLUSH_LEN);
    if (slog.size() >= 5) begin
`ifdef SRRC_DIFF_ENC_EN
      check("stall_sym1", slog[4], 3);
`else
      check("stall_sym1", slog[4], 3);
`endif
      check("stall_sym0", slog[0], 1);
      check("stall_ph", slog[1] + slog[2] + slog[3], 0);
    end
    check("stall_underrun", 32'(underrun), 1);

`ifdef SRRC_DIFF_ENC_EN
    // Differential encoding of 1,1,0,1
    do_reset();
    pat = 4'b1101;
    for (int i = 0; i < 4; i++) tick(0, 1, 1, pat[3-i]);
    repeat (20) tick(0, 1, 0, 0);
    if (slog.size() >= 13) begin
      check("diff_s0", slog[0], 3);
      check("diff_s1", slog[4], 1);
      check("diff_s2", slog[8], 1);
      check("diff_s3", slog[12], 3);
    end else check("diff_len", slog.size(), 13);
    repeat (40) tick(0, 1, 0, 0);
`endif

    // Reset mid-RUN
    do_reset();
    for (int i = 0; i < 3; i++) tick(0, 1, 1, 1);
    repeat (3) tick(0, 1, 0, 0);
    tick(1, 1, 0, 0);
    check("rst_sym_out", 32'(sym_out), 0);
    check("rst_sym_en", 32'(sym_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(bit_ready), 1);

    // Randomized traffic
    do_reset();
    dense = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) dense = ($urandom_range(0, 2) != 0);
      tick($urandom_range(0, 999) == 0,
           $urandom_range(0, 7) != 0,
           dense ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
